// File: rtl/pc_sequencer_if.sv
// Control, LUT-programming and status bundle between the decoder side and the program sequencer.
// Pure wiring, no latency or backpressure of its own.
interface pc_sequencer_if #(
  parameter int PC_W  = 12,
  parameter int LBL_W = 5,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stall;
  logic             branch;
  logic             zero;
  logic             jump;
  logic             call;
  logic             ret;
  logic [LBL_W-1:0] label;
  logic [PC_W-1:0]  halt_pc;
  logic             lut_we;
  logic [LBL_W-1:0] lut_addr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  pc;
  logic             running;
  logic             done;
  logic             fault;
  logic [CNT_W-1:0] cycles;

  modport master (
    output start, stall, branch, zero, jump, call, ret, label, halt_pc,
           lut_we, lut_addr, lut_wdata,
    input  pc, running, done, fault, cycles
  );

  modport slave (
    input  start, stall, branch, zero, jump, call, ret, label, halt_pc,
           lut_we, lut_addr, lut_wdata,
    output pc, running, done, fault, cycles
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program sequencer: PC, next-PC resolution, label LUT, return stack, run control and cycle count.
// Latency: request sampled at an edge shows on pc after that edge; backpressure: stall holds pc and stack.
module pc_sequencer #(
  parameter int PC_W      = 12,
  parameter int LBL_W     = 5,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);
  localparam int SP_W  = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int LUT_N = 1 << LBL_W;
  localparam int RAS_N = 1 << IDX_W;
  localparam logic [SP_W-1:0]  SP_FULL = SP_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  lut [LUT_N];
  logic [PC_W-1:0]  ras [RAS_N];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] top_idx;
  logic [PC_W-1:0]  pc_q, pc_nxt, pc_inc, target, top;
  logic [CNT_W-1:0] cycles_q;
  logic             done_q, fault_q;
  logic             push, pop, restart, set_done, set_fault;

  assign pc_inc  = pc_q + PC_W'(1);
  assign target  = lut[bus.label];
  assign top_idx = IDX_W'(sp - SP_W'(1));
  assign top     = ras[top_idx];

  assign bus.pc      = pc_q;
  assign bus.running = (state == RUN);
  assign bus.done    = done_q;
  assign bus.fault   = fault_q;
  assign bus.cycles  = cycles_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Halt detection outranks stall; ret > call > jump > taken branch > pc+1.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    push      = 1'b0;
    pop       = 1'b0;
    restart   = 1'b0;
    set_done  = 1'b0;
    set_fault = 1'b0;
    case (state)
      IDLE: begin
        pc_nxt = '0;
        if (bus.start) begin
          state_nxt = RUN;
          restart   = 1'b1;
        end
      end
      RUN: begin
        if (pc_q == bus.halt_pc) begin
          state_nxt = DONE;
          set_done  = 1'b1;
        end else if (!bus.stall) begin
          if (bus.ret) begin
            if (sp == '0) begin
              state_nxt = DONE;
              set_fault = 1'b1;
            end else begin
              pop    = 1'b1;
              pc_nxt = top;
            end
          end else if (bus.call) begin
            if (sp == SP_FULL) begin
              state_nxt = DONE;
              set_fault = 1'b1;
            end else begin
              push   = 1'b1;
              pc_nxt = target;
            end
          end else if (bus.jump || (bus.branch && bus.zero)) begin
            pc_nxt = target;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          restart   = 1'b1;
          pc_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      sp       <= '0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      cycles_q <= '0;
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else begin
      pc_q <= pc_nxt;
      if (restart) begin
        sp       <= '0;
        done_q   <= 1'b0;
        fault_q  <= 1'b0;
        cycles_q <= '0;
      end else begin
        if (push) begin
          ras[IDX_W'(sp)] <= pc_inc;
          sp              <= sp + SP_W'(1);
        end else if (pop) begin
          sp <= sp - SP_W'(1);
        end
        if (set_done)  done_q  <= 1'b1;
        if (set_fault) fault_q <= 1'b1;
        if (state == RUN && cycles_q != CNT_MAX) cycles_q <= cycles_q + CNT_W'(1);
      end
      // Write lands after this cycle's read, so a same-index read sees the old entry.
      if (bus.lut_we) lut[bus.lut_addr] <= bus.lut_wdata;
    end
  end
endmodule
